// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_arbiter
// Brief    : Shares one single-port memory bus between the fetch (IF) and
//            memory (DM) stages; one outstanding transaction, DM-priority with
//            a burst limit, and silent discard of flushed fetch responses.
// Revision : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter #(
  parameter int AW          = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  input  logic          i_flush_if,
  output logic          o_if_rvalid,
  output logic [31:0]   o_if_rdata,
  output logic          o_if_stall,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [31:0]   i_dm_wdata,
  input  logic [3:0]    i_dm_wstrb,
  output logic          o_dm_rvalid,
  output logic [31:0]   o_dm_rdata,
  output logic          o_dm_stall,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_wstrb,
  input  logic          i_mem_gnt,
  input  logic          i_mem_rvalid,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] C_MAX_BURST = 4'(MAX_D_BURST);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_owner_if;
  logic            r_drop;
  logic [3:0]      r_burst_cnt;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic [3:0]      r_mem_wstrb;
  logic [31:0]     r_if_rdata;
  logic [31:0]     r_dm_rdata;

  logic            w_if_elig;
  logic            w_grant_dm;
  logic            w_grant_if;
  logic            w_flush_own;
  logic            w_capture;
  logic            w_if_rvalid;
  logic            w_dm_rvalid;

  // A fetch flushed in the same cycle it is requested is wrong-path already.
  assign w_if_elig   = i_if_req & ~i_flush_if;
  assign w_grant_dm  = i_dm_req & ~(w_if_elig & (r_burst_cnt == C_MAX_BURST));
  assign w_grant_if  = w_if_elig & ~w_grant_dm;
  assign w_flush_own = r_owner_if & i_flush_if;
  assign w_capture   = (r_state == S_RESP) & i_mem_rvalid;

  always_comb begin
    w_state_nxt = r_state;
    w_if_rvalid = 1'b0;
    w_dm_rvalid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_dm | w_grant_if) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (i_mem_gnt) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (i_mem_rvalid) w_state_nxt = (r_drop | w_flush_own) ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_if_rvalid = r_owner_if & ~i_flush_if;
        w_dm_rvalid = ~r_owner_if;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_owner_if  <= 1'b0;
      r_drop      <= 1'b0;
      r_burst_cnt <= 4'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_if_rdata  <= 32'd0;
      r_dm_rdata  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE) begin
        if (w_grant_dm) begin
          r_owner_if  <= 1'b0;
          r_mem_we    <= i_dm_we;
          r_mem_addr  <= i_dm_addr;
          r_mem_wdata <= i_dm_wdata;
          r_mem_wstrb <= i_dm_we ? i_dm_wstrb : 4'd0;
          // Count only DM wins that made a waiting fetch wait longer.
          if (!i_if_req)
            r_burst_cnt <= 4'd0;
          else if (r_burst_cnt != C_MAX_BURST)
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end else if (w_grant_if) begin
          r_owner_if  <= 1'b1;
          r_mem_we    <= 1'b0;
          r_mem_addr  <= i_if_addr;
          r_mem_wdata <= 32'd0;
          r_mem_wstrb <= 4'd0;
          r_burst_cnt <= 4'd0;
        end
      end

      if (w_state_nxt == S_IDLE)
        r_drop <= 1'b0;
      else if (((r_state == S_REQ) || (r_state == S_RESP)) && w_flush_own)
        r_drop <= 1'b1;

      if (w_capture) begin
        if (r_owner_if) r_if_rdata <= i_mem_rdata;
        else            r_dm_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_if_rvalid = w_if_rvalid;
  assign o_dm_rvalid = w_dm_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_if_stall  = i_if_req & ~w_if_rvalid;
  assign o_dm_stall  = i_dm_req & ~w_dm_rvalid;
  assign o_mem_req   = (r_state == S_REQ);
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;
  assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_dmem_arbiter
// Brief    : Random IF/DM/bus traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

  localparam int AW   = 32;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_if_req = 1'b0;
  logic [AW-1:0] i_if_addr = 32'h100;
  logic          i_flush_if = 1'b0;
  logic          o_if_rvalid;
  logic [31:0]   o_if_rdata;
  logic          o_if_stall;
  logic          i_dm_req = 1'b0;
  logic          i_dm_we = 1'b0;
  logic [AW-1:0] i_dm_addr = '0;
  logic [31:0]   i_dm_wdata = 32'd0;
  logic [3:0]    i_dm_wstrb = 4'd0;
  logic          o_dm_rvalid;
  logic [31:0]   o_dm_rdata;
  logic          o_dm_stall;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [3:0]    o_mem_wstrb;
  logic          i_mem_gnt = 1'b0;
  logic          i_mem_rvalid = 1'b0;
  logic [31:0]   i_mem_rdata = 32'd0;
  logic          o_busy;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.AW(AW), .MAX_D_BURST(MAXB)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_flush_if(i_flush_if),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata), .o_if_stall(o_if_stall),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_wstrb(i_dm_wstrb),
    .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata), .o_dm_stall(o_dm_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Current transaction as seen from outside: who owns it and how far it got.
  bit          t_open, t_is_if, t_accepted, t_answered, t_dropped;
  logic        t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_wstrb;
  int          dm_streak;
  logic [31:0] m_if_rdata, m_dm_rdata;

  bit          mem_pending;
  int          mem_wait;
  bit          prev_if_done, prev_dm_done, force_stray;
  int          resets_done;
  int          dm_rate, gnt_rate;

  int dm_rate_tbl  [8] = '{90, 95, 40, 100, 70, 20, 100, 60};
  int gnt_rate_tbl [8] = '{100, 60, 30, 90, 15, 80, 100, 50};

  task automatic clear_model();
    t_open = 0; t_is_if = 0; t_accepted = 0; t_answered = 0; t_dropped = 0;
    dm_streak = 0; m_if_rdata = 32'd0; m_dm_rdata = 32'd0;
    mem_pending = 0; mem_wait = 0; prev_if_done = 0; prev_dm_done = 0;
  endtask

  task automatic check_all_zero(input string where);
    check({where, "_mem_req"},   o_mem_req,   0);
    check({where, "_mem_we"},    o_mem_we,    0);
    check({where, "_mem_addr"},  o_mem_addr,  0);
    check({where, "_mem_wdata"}, o_mem_wdata, 0);
    check({where, "_mem_wstrb"}, o_mem_wstrb, 0);
    check({where, "_if_rvalid"}, o_if_rvalid, 0);
    check({where, "_dm_rvalid"}, o_dm_rvalid, 0);
    check({where, "_if_rdata"},  o_if_rdata,  0);
    check({where, "_dm_rdata"},  o_dm_rdata,  0);
    check({where, "_if_stall"},  o_if_stall,  0);
    check({where, "_dm_stall"},  o_dm_stall,  0);
    check({where, "_busy"},      o_busy,      0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_if_req = 0; i_dm_req = 0; i_flush_if = 0; i_mem_gnt = 0; i_mem_rvalid = 0;
    #2 i_reset = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    clear_model();
    force_stray = 1;
  endtask

  initial begin
    bit e_req, e_done, e_if_rv, e_dm_rv, if_elig;
    clear_model();
    resets_done = 0;
    force_stray = 0;
    @(negedge clk);
    #1 check_all_zero("por");
    @(negedge clk);
    i_reset = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      dm_rate  = dm_rate_tbl[(cyc / 500) % 8];
      gnt_rate = gnt_rate_tbl[(cyc / 500) % 8];

      // Reset in the middle of a response wait, then offer a stray rvalid.
      if (cyc > 300 && resets_done < 3 && cyc % 900 > 800 &&
          t_open && t_accepted && !t_answered) begin
        do_reset();
        resets_done++;
      end

      @(negedge clk);
      if (i_if_req && prev_if_done) i_if_req = 0;
      if (!i_if_req && $urandom_range(0, 2) == 0) begin
        i_if_req  = 1;
        i_if_addr = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFC) : i_if_addr + 32'd4;
      end
      if (i_dm_req && prev_dm_done) i_dm_req = 0;
      if (!i_dm_req && $urandom_range(1, 100) <= dm_rate) begin
        i_dm_req   = 1;
        i_dm_we    = $urandom_range(0, 1);
        i_dm_addr  = $urandom & 32'hFFFF_FFFC;
        i_dm_wdata = $urandom;
        i_dm_wstrb = 4'($urandom_range(0, 15));
      end
      i_flush_if   = ($urandom_range(0, 9) == 0);
      i_mem_gnt    = ($urandom_range(1, 100) <= gnt_rate);
      i_mem_rdata  = $urandom;
      if (mem_pending) begin
        if (mem_wait == 0) begin
          i_mem_rvalid = 1;
          mem_pending  = 0;
        end else begin
          i_mem_rvalid = 0;
          mem_wait--;
        end
      end else begin
        i_mem_rvalid = force_stray || ($urandom_range(0, 7) == 0);
      end
      force_stray = 0;

      e_req   = t_open && !t_accepted;
      e_done  = t_open && t_answered;
      e_if_rv = e_done && t_is_if && !i_flush_if;
      e_dm_rv = e_done && !t_is_if;

      #1;
      check("mem_req", o_mem_req, e_req);
      if (e_req) begin
        check("mem_addr",  o_mem_addr,  t_addr);
        check("mem_we",    o_mem_we,    t_we);
        check("mem_wdata", o_mem_wdata, t_wdata);
        check("mem_wstrb", o_mem_wstrb, t_wstrb);
      end
      check("if_rvalid", o_if_rvalid, e_if_rv);
      check("dm_rvalid", o_dm_rvalid, e_dm_rv);
      check("if_rdata",  o_if_rdata,  m_if_rdata);
      check("dm_rdata",  o_dm_rdata,  m_dm_rdata);
      check("if_stall",  o_if_stall,  i_if_req && !e_if_rv);
      check("dm_stall",  o_dm_stall,  i_dm_req && !e_dm_rv);
      check("busy",      o_busy,      t_open);
      prev_if_done = e_if_rv || i_flush_if;
      prev_dm_done = e_dm_rv;

      @(posedge clk);
      if (!t_open) begin
        if_elig = i_if_req && !i_flush_if;
        if (i_dm_req && !(if_elig && dm_streak == MAXB)) begin
          t_open = 1; t_is_if = 0; t_accepted = 0; t_answered = 0; t_dropped = 0;
          t_we = i_dm_we; t_addr = i_dm_addr; t_wdata = i_dm_wdata;
          t_wstrb = i_dm_we ? i_dm_wstrb : 4'd0;
          dm_streak = i_if_req ? ((dm_streak < MAXB) ? dm_streak + 1 : MAXB) : 0;
        end else if (if_elig) begin
          t_open = 1; t_is_if = 1; t_accepted = 0; t_answered = 0; t_dropped = 0;
          t_we = 0; t_addr = i_if_addr; t_wdata = 32'd0; t_wstrb = 4'd0;
          dm_streak = 0;
        end
      end else if (!t_accepted) begin
        if (i_flush_if && t_is_if) t_dropped = 1;
        if (i_mem_gnt) begin
          t_accepted  = 1;
          mem_pending = 1;
          mem_wait    = $urandom_range(0, 2);
        end
      end else if (!t_answered) begin
        if (i_mem_rvalid) begin
          if (t_is_if) m_if_rdata = i_mem_rdata;
          else         m_dm_rdata = i_mem_rdata;
          if (t_dropped || (i_flush_if && t_is_if)) t_open = 0;
          else t_answered = 1;
        end else if (i_flush_if && t_is_if) begin
          t_dropped = 1;
        end
      end else begin
        t_open = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port memory bus between the fetch stage (instruction port, IF) and the memory stage (data port, DM) of the 5-stage RV32 pipeline.
- Has one outstanding transaction at a time. Data requests win by default; a burst limit prevents fetch starvation.
- Produces per-port stall signals, which the hazard unit ORs into its fetch and decode stalls. Also discards wrong-path fetch responses on i_flush_if.

Parameters:
- AW, 32, address width of both ports and the bus.
- MAX_D_BURST, 4, maximum consecutive DM grants while IF is pending before IF is forced; legal range 1..15.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_if_req  in  1  fetch read request; held with its address until o_if_rvalid or flush.
- i_if_addr  in  AW  fetch address.
- i_flush_if  in  1  discard any in-flight or completing fetch.
- o_if_rvalid  out  1  fetch data valid, one-cycle pulse.
- o_if_rdata  out  32  fetched instruction.
- o_if_stall  out  1  fetch must hold.
- i_dm_req  in  1  data request; held stable until o_dm_rvalid.
- i_dm_we  in  1  1 = store.
- i_dm_addr  in  AW  data address.
- i_dm_wdata  in  32  store data.
- i_dm_wstrb  in  4  store byte enables.
- o_dm_rvalid  out  1  load data / store ack, one-cycle pulse.
- o_dm_rdata  out  32  load data.
- o_dm_stall  out  1  memory stage must hold.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  bus write enable.
- o_mem_addr  out  AW  bus address.
- o_mem_wdata  out  32  bus write data.
- o_mem_wstrb  out  4  bus byte enables; 0 for reads.
- i_mem_gnt  in  1  bus accepted request this cycle.
- i_mem_rvalid  in  1  response valid; exactly one per accepted request, earliest the cycle after gnt.
- i_mem_rdata  in  32  response data.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (i_reset=0, async): state=IDLE, owner=DM, drop flag=0, burst counter=0, all outputs 0.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: if any request is present, select the owner, latch its payload (IF: we=0, wstrb=0, wdata=0), go to REQ.
    - Exception: i_if_req with i_flush_if in the same cycle is not eligible.
  - REQ: o_mem_req=1 with latched payload, held stable until i_mem_gnt. On gnt go to RESP.
  - RESP: wait for i_mem_rvalid. On rvalid, capture i_mem_rdata into the owner's rdata register. Then go to DONE, or to IDLE if the drop flag is set or i_flush_if=1 that cycle with owner=IF.
  - DONE: pulse the owner's o_x_rvalid for 1 cycle, then go to IDLE.
    - If owner=IF and i_flush_if=1 in DONE, the pulse is suppressed.
- Minimum latency: request at cycle 0, o_mem_req at 1, gnt at 1, rvalid at 2, o_x_rvalid at 3.
- A request seen in IDLE is always a new request: requesters advance on the rvalid cycle.
- Stalls are combinational:
  - o_if_stall = i_if_req & ~o_if_rvalid.
  - o_dm_stall = i_dm_req & ~o_dm_rvalid.
- Arbitration when both requests are present in IDLE:
  - DM wins unless burst counter == MAX_D_BURST.
  - The counter increments on each DM grant made while i_if_req=1, and saturates.
  - The counter clears on any IF grant, or on a DM grant made while i_if_req=0.
- Flush:
  - i_flush_if while owner=IF in REQ or RESP sets the drop flag.
  - A REQ already on the bus is never withdrawn. The response is consumed silently and o_if_rvalid is never pulsed.
  - The drop flag clears on entering IDLE.
  - i_flush_if has no effect on a DM transaction.
- i_mem_rvalid in IDLE or REQ, or i_mem_gnt outside REQ: ignored, no state change.
- o_x_rdata holds its value until the next capture for that port.
- Reset mid-transaction: return to IDLE immediately. A late rvalid after reset is ignored per the rule above.

Test Plan:
- IF read 0x100, gnt same cycle as o_mem_req, rvalid 2 cycles later, rdata 0x00500093 -> o_if_rvalid pulse at cycle 4 with that data; o_if_stall=1 cycles 0-3, 0 at 4.
- IF and DM request same cycle, DM store 0x200 data 0xDEADBEEF wstrb 0xF -> bus carries the store first with we=1; IF is granted only after o_dm_rvalid; o_if_stall high throughout.
- DM requests back-to-back with IF pending, MAX_D_BURST=4 -> exactly 4 DM grants, then an IF grant, then the counter restarts.
- i_flush_if pulsed while IF is in RESP -> rvalid consumed, o_if_rvalid stays 0, FSM returns to IDLE, next IF request 0x104 served normally.
- gnt withheld 5 cycles -> o_mem_req, addr, we, wdata and wstrb stable all 5 cycles; one transaction only.
- i_reset=0 during RESP, released, then stray rvalid -> all outputs 0, state IDLE, no o_x_rvalid pulse.
